// File: rtl/mem_responder_if.sv
// Request/response bundle of the picorv32-style memory bus, plus the sticky error
// flag the responder reports back beside it.
interface mem_responder_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        bus_error;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata, bus_error
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata, bus_error
   );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM answering one picorv32-style request at a time, with separate
// programmable wait states for fetches and data accesses and a sticky range error.
module mem_responder #(
   parameter int          DEPTH_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          INSTR_LATENCY = 1,
   parameter int          DATA_LATENCY  = 2
) (
   input logic            clk,
   input logic            reset,
   mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  count_reg, count_next;
   logic        mem_ready_reg;
   logic [31:0] mem_rdata_reg;
   logic        bus_error_reg;

   logic [AW-1:0] index_reg;
   logic          in_range_reg;
   logic [31:0]   wdata_reg;
   logic [3:0]    wstrb_reg;

   logic          accept;
   logic          access;
   logic [3:0]    lane_we;

   logic [31:0]   mem_array [DEPTH_WORDS];
   logic [31:0]   ram_rd_reg;

   // Address decode; the subtraction wraps so addresses below the base land out of range.
   logic [31:0]   offset;
   logic          req_in_range;
   logic [AW-1:0] req_index;
   logic          addr_lsb_unused;

   assign offset          = bus.mem_addr - BASE_ADDR;
   assign req_in_range    = (offset[31:AW+2] == '0);
   assign req_index       = offset[AW+1:2];
   assign addr_lsb_unused = ^offset[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         count_reg     <= 4'd0;
         mem_ready_reg <= 1'b0;
         mem_rdata_reg <= 32'h0000_0000;
         bus_error_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         mem_ready_reg <= access;
         if (access) begin
            mem_rdata_reg <= in_range_reg ? ram_rd_reg : 32'h0000_0000;
            if (!in_range_reg) begin
               bus_error_reg <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (bus.mem_valid) begin
               state_next = WAIT;
               count_next = bus.mem_instr ? 4'(INSTR_LATENCY) : 4'(DATA_LATENCY);
            end
         end
         WAIT: begin
            if (!bus.mem_valid) begin
               state_next = IDLE;
               count_next = 4'd0;
            end else if (count_reg == 4'd1) begin
               state_next = DONE;
               count_next = 4'd0;
            end else begin
               count_next = count_reg - 4'd1;
            end
         end
         DONE: begin
            if (!bus.mem_valid) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = 4'd0;
         end
      endcase
   end

   // A dropped valid on the expiry edge suppresses the access, hence the valid term.
   always_comb begin
      accept = 1'b0;
      access = 1'b0;
      case (state_reg)
         IDLE:    accept = bus.mem_valid;
         WAIT:    access = bus.mem_valid && (count_reg == 4'd1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         index_reg    <= req_index;
         in_range_reg <= req_in_range;
         wdata_reg    <= bus.mem_wdata;
         wstrb_reg    <= bus.mem_wstrb;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
         assign lane_we[gi] = access && in_range_reg && wstrb_reg[gi];
      end
   endgenerate

   // The word is fetched at accept; no write can land before this request completes.
   always_ff @(posedge clk) begin
      if (accept) begin
         ram_rd_reg <= mem_array[req_index];
      end
      for (int i = 0; i < 4; i++) begin
         if (lane_we[i]) begin
            mem_array[index_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
         end
      end
   end

   assign bus.mem_ready = mem_ready_reg;
   assign bus.mem_rdata = mem_rdata_reg;
   assign bus.bus_error = bus_error_reg;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed bring-up steps then random traffic, all checked
// against a word-array model with per-lane merge, latency table and sticky error bit.
module tb_mem_responder;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          IL    = 1;
   localparam int          DL    = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mem_responder_if bus_if ();

   mem_responder #(
      .DEPTH_WORDS   (DEPTH),
      .BASE_ADDR     (BASE),
      .INSTR_LATENCY (IL),
      .DATA_LATENCY  (DL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_mem [int unsigned];
   logic        model_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (off / 32'd4) < 32'(DEPTH);
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   // One core-style transaction; abort_at>0 drops valid so the WAIT state sees it low
   // on the abort_at-th edge after accept.
   task automatic run_req(input string tag, input bit instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int abort_at, output logic [31:0] rdata_seen);
      int          lat_exp;
      int          cnt;
      bit          ok;
      int unsigned w;
      logic [31:0] exp_rd;
      lat_exp = instr ? IL : DL;
      ok      = addr_in_range(addr);
      w       = int'((addr - BASE) >> 2);
      exp_rd  = 32'h0;
      if (ok && model_mem.exists(w)) exp_rd = model_mem[w];
      rdata_seen = 32'h0;

      @(negedge clk);
      bus_if.mem_valid = 1'b1;
      bus_if.mem_instr = instr;
      bus_if.mem_addr  = addr;
      bus_if.mem_wdata = wdata;
      bus_if.mem_wstrb = wstrb;
      @(negedge clk);
      // Scramble inputs during WAIT; the responder must have captured them at accept.
      bus_if.mem_addr  = $urandom;
      bus_if.mem_wdata = $urandom;
      bus_if.mem_wstrb = 4'($urandom_range(0, 15));

      if (abort_at > 0) begin
         for (int k = 1; k < abort_at; k++) begin
            check({tag, "_pre_abort_ready"}, 32'(bus_if.mem_ready), 32'd0);
            @(negedge clk);
         end
         bus_if.mem_valid = 1'b0;
         for (int k = 0; k <= lat_exp; k++) begin
            @(negedge clk);
            check({tag, "_abort_ready"}, 32'(bus_if.mem_ready), 32'd0);
         end
         $display("txn %s instr=%0d addr=%h wstrb=%b aborted after %0d", tag, instr, addr,
                  wstrb, abort_at);
         return;
      end

      cnt = 0;
      while (bus_if.mem_ready !== 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, "_latency"}, 32'(cnt), 32'(lat_exp));
      rdata_seen = bus_if.mem_rdata;
      if (wstrb == 4'b0000) check({tag, "_rdata"}, rdata_seen, exp_rd);

      if (ok && wstrb != 4'b0000) begin
         model_mem[w] = lane_merge(model_mem.exists(w) ? model_mem[w] : 32'h0, wdata, wstrb);
      end
      if (!ok) model_err = 1'b1;

      // Valid stays high into DONE: no second ready, rdata and error flag hold.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check({tag, "_held_ready"}, 32'(bus_if.mem_ready), 32'd0);
         check({tag, "_held_rdata"}, bus_if.mem_rdata, rdata_seen);
         check({tag, "_bus_error"}, 32'(bus_if.bus_error), 32'(model_err));
      end
      bus_if.mem_valid = 1'b0;
      $display("txn %s instr=%0d addr=%h wdata=%h wstrb=%b lat=%0d rdata=%h err=%0d", tag,
               instr, addr, wdata, wstrb, cnt, rdata_seen, bus_if.bus_error);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] pool [8];
      logic [31:0] addr;
      logic [3:0]  strb;
      bit          instr;
      int          ab;

      bus_if.mem_valid = 1'b0;
      bus_if.mem_instr = 1'b0;
      bus_if.mem_addr  = 32'h0;
      bus_if.mem_wdata = 32'h0;
      bus_if.mem_wstrb = 4'h0;

      #2;
      check("reset_ready", 32'(bus_if.mem_ready), 32'd0);
      check("reset_rdata", bus_if.mem_rdata, 32'd0);
      check("reset_bus_error", 32'(bus_if.bus_error), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      run_req("wr_w0", 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 0, rd);
      run_req("wr_10", 1'b0, 32'h0000_0010, 32'hA5A5_5A5A, 4'b1111, 0, rd);
      run_req("rd_10", 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, rd);
      check("rd_10_const", rd, 32'hA5A5_5A5A);

      run_req("wr_10_lane0", 1'b0, 32'h0000_0010, 32'h0000_00FF, 4'b0001, 0, rd);
      run_req("wr_10_lane3", 1'b0, 32'h0000_0010, 32'h1100_0000, 4'b1000, 0, rd);
      run_req("rd_10_lanes", 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, rd);
      check("rd_10_lanes_const", rd, 32'h11A5_5AFF);

      run_req("fetch_10", 1'b1, 32'h0000_0010, 32'h0, 4'b0000, 0, rd);
      run_req("data_10", 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, rd);

      run_req("oor_rd", 1'b0, 32'h0000_1000, 32'h0, 4'b0000, 0, rd);
      check("oor_rd_zero", rd, 32'h0);
      check("oor_err_sticky", 32'(bus_if.bus_error), 32'd1);
      run_req("oor_wr", 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 0, rd);
      run_req("rd_w0", 1'b0, 32'h0000_0000, 32'h0, 4'b0000, 0, rd);
      check("rd_w0_const", rd, 32'hCAFE_F00D);

      run_req("wr_20", 1'b0, 32'h0000_0020, 32'h1234_5678, 4'b1111, 0, rd);
      run_req("abort1_20", 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 1, rd);
      run_req("rd_20_a", 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, rd);
      check("rd_20_a_const", rd, 32'h1234_5678);
      run_req("abort_exp_20", 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, DL, rd);
      run_req("rd_20_b", 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, rd);
      check("rd_20_b_const", rd, 32'h1234_5678);

      // Asynchronous reset in the middle of a write's WAIT.
      @(negedge clk);
      bus_if.mem_valid = 1'b1;
      bus_if.mem_instr = 1'b0;
      bus_if.mem_addr  = 32'h0000_0020;
      bus_if.mem_wdata = 32'hFFFF_FFFF;
      bus_if.mem_wstrb = 4'b1111;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_ready", 32'(bus_if.mem_ready), 32'd0);
      check("midrst_bus_error", 32'(bus_if.bus_error), 32'd0);
      check("midrst_rdata", bus_if.mem_rdata, 32'd0);
      model_err = 1'b0;
      bus_if.mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      $display("txn midrst addr=00000020 write cancelled by reset");
      run_req("rd_20_rst", 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, rd);
      check("rd_20_rst_const", rd, 32'h1234_5678);

      pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0010;
      pool[2] = 32'h0000_0020; pool[3] = 32'h0000_0040;
      pool[4] = 32'h0000_0100; pool[5] = 32'h0000_03F0;
      pool[6] = 32'h0000_0800; pool[7] = 32'h0000_0FFC;
      for (int i = 3; i < 8; i++) begin
         run_req("init", 1'b0, pool[i], $urandom, 4'b1111, 0, rd);
      end

      for (int t = 0; t < 80; t++) begin
         addr  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
         instr = 1'($urandom_range(0, 1));
         strb  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
         ab    = 0;
         if ($urandom_range(0, 7) == 0) begin
            addr = 32'h0000_1000 + 32'($urandom_range(0, 32'h7FFF_0000));
         end else if ($urandom_range(0, 7) == 0) begin
            ab = $urandom_range(1, instr ? IL : DL);
         end
         run_req("rand", instr, addr, $urandom, strb, ab, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
